// File: rtl/yaki_router_pkg.sv
// rtl/yaki_router_pkg.sv - shared widths, arbiter states and header field helpers
package yaki_router_pkg;

    localparam int DATA_SIZE       = 8;
    localparam int PKT_LENGTH_BITS = 5;
    localparam int PKT_ADDR_BITS   = DATA_SIZE - PKT_LENGTH_BITS;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HDR  = 2'd1,
        PLD  = 2'd2
    } arb_state_t;

    // Header layout: length in the upper bits, destination address in the lower bits.
    function automatic logic [PKT_LENGTH_BITS-1:0] hdr_length(input logic [DATA_SIZE-1:0] hdr);
        return hdr[DATA_SIZE-1:PKT_ADDR_BITS];
    endfunction

    function automatic logic [PKT_ADDR_BITS-1:0] hdr_addr(input logic [DATA_SIZE-1:0] hdr);
        return hdr[PKT_ADDR_BITS-1:0];
    endfunction

endpackage

// File: rtl/yaki_rr_picker.sv
// rtl/yaki_rr_picker.sv - combinational round-robin one-hot selector
module yaki_rr_picker #(
    parameter int NUM_CHN = 4,
    parameter int PTR_W   = 2
) (
    input  logic [NUM_CHN-1:0] req,
    input  logic [PTR_W-1:0]   rr_ptr,
    output logic [NUM_CHN-1:0] gnt
);

    int   idx;
    logic found;

    // Scan starting at rr_ptr and wrap; the first requester wins.
    always_comb begin
        gnt   = '0;
        found = 1'b0;
        idx   = 0;
        for (int i = 0; i < NUM_CHN; i++) begin
            idx = int'(rr_ptr) + i;
            if (idx >= NUM_CHN) begin
                idx = idx - NUM_CHN;
            end
            if (!found && req[idx]) begin
                gnt[idx] = 1'b1;
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/yaki_out_arbiter.sv
// rtl/yaki_out_arbiter.sv - packet-granular round-robin arbiter from channel FIFOs to one output
module yaki_out_arbiter #(
    parameter int NUM_CHN         = 4,
    parameter int DATA_SIZE       = yaki_router_pkg::DATA_SIZE,
    parameter int PKT_LENGTH_BITS = yaki_router_pkg::PKT_LENGTH_BITS
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_CHN-1:0]             fifo_empty,
    input  logic [NUM_CHN*DATA_SIZE-1:0]   fifo_data,
    output logic [NUM_CHN-1:0]             fifo_rd_en,
    input  logic                           out_ready,
    output logic [DATA_SIZE-1:0]           data_out,
    output logic                           out_valid,
    output logic [NUM_CHN-1:0]             grant,
    output logic                           busy,
    output logic                           pkt_done
);

    import yaki_router_pkg::*;

    localparam int PTR_W = (NUM_CHN > 1) ? $clog2(NUM_CHN) : 1;

    arb_state_t                 state, state_nxt;
    logic [PTR_W-1:0]           rr_ptr, g_idx, pick_idx, nxt_ptr;
    logic [PKT_LENGTH_BITS-1:0] cnt;
    logic [NUM_CHN-1:0]         pick;
    logic [DATA_SIZE-1:0]       head;
    logic                       any_req, rd, pkt_end;

    yaki_rr_picker #(
        .NUM_CHN (NUM_CHN),
        .PTR_W   (PTR_W)
    ) u_picker (
        .req    (~fifo_empty),
        .rr_ptr (rr_ptr),
        .gnt    (pick)
    );

    always_comb begin
        pick_idx = '0;
        for (int i = 0; i < NUM_CHN; i++) begin
            if (pick[i]) begin
                pick_idx = PTR_W'(i);
            end
        end
    end

    assign any_req = |(~fifo_empty);
    assign head    = fifo_data[int'(g_idx)*DATA_SIZE +: DATA_SIZE];
    assign nxt_ptr = (int'(g_idx) == NUM_CHN-1) ? '0 : g_idx + 1'b1;
    assign busy    = (state != IDLE);

    // While granted, grant is exactly the owner's one-hot, so it doubles as the read strobe.
    assign fifo_rd_en = (rd && !rst) ? grant : '0;

    always_comb begin
        state_nxt = state;
        rd        = 1'b0;
        pkt_end   = 1'b0;
        unique case (state)
            IDLE: begin
                if (any_req) begin
                    state_nxt = HDR;
                end
            end
            HDR: begin
                if (out_ready && !fifo_empty[g_idx]) begin
                    rd = 1'b1;
                    if (hdr_length(head) == '0) begin
                        state_nxt = IDLE;
                        pkt_end   = 1'b1;
                    end else begin
                        state_nxt = PLD;
                    end
                end
            end
            PLD: begin
                if (out_ready && !fifo_empty[g_idx]) begin
                    rd = 1'b1;
                    if (cnt == PKT_LENGTH_BITS'(1)) begin
                        state_nxt = IDLE;
                        pkt_end   = 1'b1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            g_idx     <= '0;
            grant     <= '0;
            cnt       <= '0;
            data_out  <= '0;
            out_valid <= 1'b0;
            pkt_done  <= 1'b0;
        end else begin
            state    <= state_nxt;
            pkt_done <= pkt_end;
            if (state == IDLE && any_req) begin
                grant <= pick;
                g_idx <= pick_idx;
            end
            if (pkt_end) begin
                grant  <= '0;
                rr_ptr <= nxt_ptr;
            end
            if (rd) begin
                cnt <= (state == HDR) ? hdr_length(head) : cnt - 1'b1;
            end
            // A stalled output keeps its byte; a ready cycle without a read retires it.
            if (out_ready) begin
                out_valid <= rd;
                if (rd) begin
                    data_out <= head;
                end
            end
        end
    end

endmodule

// File: tb/tb_yaki_out_arbiter.sv
// tb/tb_yaki_out_arbiter.sv - directed scoreboard bench for yaki_out_arbiter
module tb_yaki_out_arbiter;

    localparam int N = 4;
    localparam int W = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rst;
    logic           out_ready;
    logic [N-1:0]   fifo_empty;
    logic [N*W-1:0] fifo_data;
    logic [N-1:0]   fifo_rd_en;
    logic [W-1:0]   data_out;
    logic           out_valid;
    logic [N-1:0]   grant;
    logic           busy;
    logic           pkt_done;

    logic [7:0] fq [N][$];
    logic [7:0] exp_q [$];
    int rd_count [N];
    int errors = 0;
    int checks = 0;

    yaki_out_arbiter #(
        .NUM_CHN         (N),
        .DATA_SIZE       (W),
        .PKT_LENGTH_BITS (5)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .fifo_empty (fifo_empty),
        .fifo_data  (fifo_data),
        .fifo_rd_en (fifo_rd_en),
        .out_ready  (out_ready),
        .data_out   (data_out),
        .out_valid  (out_valid),
        .grant      (grant),
        .busy       (busy),
        .pkt_done   (pkt_done)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic refresh();
        for (int i = 0; i < N; i++) begin
            fifo_empty[i]       = (fq[i].size() == 0);
            fifo_data[i*W +: W] = (fq[i].size() != 0) ? fq[i][0] : 8'h00;
        end
    endtask

    task automatic push_byte(input int ch, input logic [7:0] b, input bit expect_out);
        fq[ch].push_back(b);
        if (expect_out) exp_q.push_back(b);
        refresh();
    endtask

    // Called at a falling edge; returns at the next falling edge with FIFOs and scoreboard updated.
    task automatic tick();
        logic [N-1:0] rd;
        logic         rdy;
        logic [7:0]   e;
        #1;
        rd  = fifo_rd_en;
        rdy = out_ready;
        @(posedge clk);
        for (int i = 0; i < N; i++) begin
            if (rd[i] && fq[i].size() != 0) begin
                void'(fq[i].pop_front());
                rd_count[i]++;
            end
        end
        @(negedge clk);
        refresh();
        if (rdy && out_valid) begin
            checks++;
            assert (exp_q.size() != 0) else begin
                errors++;
                $error("FAIL sb_extra observed=%0h expected=none", data_out);
            end
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("sb_data", data_out, e);
            end
        end
    endtask

    initial begin
        rst       = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < N; i++) rd_count[i] = 0;
        refresh();
        @(negedge clk);
        tick();
        tick();

        check("rst_grant", grant, 0);
        check("rst_busy", busy, 0);
        check("rst_valid", out_valid, 0);
        check("rst_data", data_out, 0);
        check("rst_done", pkt_done, 0);
        check("rst_rd_en", fifo_rd_en, 0);
        rst = 1'b0;

        // single packet on ch0
        push_byte(0, 8'h12, 1);
        push_byte(0, 8'hAA, 1);
        push_byte(0, 8'hBB, 1);
        tick();
        check("p1_grant", grant, 4'b0001);
        check("p1_busy", busy, 1);
        tick();
        check("p1_hdr", data_out, 8'h12);
        check("p1_hdr_valid", out_valid, 1);
        tick();
        check("p1_b1", data_out, 8'hAA);
        tick();
        check("p1_b2", data_out, 8'hBB);
        check("p1_done", pkt_done, 1);
        check("p1_grant_end", grant, 0);
        tick();
        check("p1_done_pulse", pkt_done, 0);
        check("p1_idle", busy, 0);
        check("p1_valid_drop", out_valid, 0);

        // fairness from rr_ptr = 0
        rst = 1'b1;
        tick();
        rst = 1'b0;
        push_byte(0, 8'h00, 1);
        push_byte(1, 8'h01, 1);
        push_byte(2, 8'h02, 1);
        push_byte(3, 8'h03, 1);
        push_byte(0, 8'h04, 1);
        for (int k = 0; k < 5; k++) begin
            for (int t = 0; t < 10 && grant == '0; t++) tick();
            check("fair_grant", grant, 32'(1) << (k % 4));
            tick();
        end
        tick();
        check("fair_drained", exp_q.size(), 0);

        // backpressure mid-payload on ch2
        push_byte(2, 8'h22, 1);
        for (int i = 0; i < 4; i++) push_byte(2, 8'h31 + 8'(i), 1);
        for (int t = 0; t < 10 && !(out_valid && data_out == 8'h31); t++) tick();
        check("bp_first", data_out, 8'h31);
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("bp_data_hold", data_out, 8'h31);
            check("bp_valid_hold", out_valid, 1);
            check("bp_rd_en", fifo_rd_en, 0);
        end
        out_ready = 1'b1;
        for (int t = 0; t < 10 && !pkt_done; t++) tick();
        check("bp_done", pkt_done, 1);
        check("bp_drained", exp_q.size(), 0);

        // underflow on ch1
        push_byte(1, 8'h19, 1);
        push_byte(1, 8'h41, 1);
        for (int t = 0; t < 10 && !(out_valid && data_out == 8'h41); t++) tick();
        check("uf_first", data_out, 8'h41);
        for (int k = 0; k < 5; k++) begin
            tick();
            check("uf_grant", grant, 4'b0010);
            check("uf_valid", out_valid, 0);
        end
        push_byte(1, 8'h42, 1);
        push_byte(1, 8'h43, 1);
        for (int t = 0; t < 10 && !pkt_done; t++) tick();
        check("uf_done", pkt_done, 1);
        check("uf_grant_end", grant, 0);
        check("uf_drained", exp_q.size(), 0);

        // reset mid-payload on ch3
        push_byte(3, 8'h2B, 1);
        for (int i = 0; i < 5; i++) push_byte(3, 8'h51 + 8'(i), 1);
        for (int t = 0; t < 10 && grant == '0; t++) tick();
        check("rs_grant3", grant, 4'b1000);
        push_byte(0, 8'h00, 0);
        push_byte(2, 8'h02, 0);
        for (int t = 0; t < 10 && !(out_valid && data_out == 8'h52); t++) tick();
        check("rs_mid", data_out, 8'h52);
        check("rs_owner", grant, 4'b1000);
        rst = 1'b1;
        #1;
        check("rs_rd_en", fifo_rd_en, 0);
        exp_q.delete();
        fq[3].delete();
        refresh();
        tick();
        check("rs_grant", grant, 0);
        check("rs_busy", busy, 0);
        check("rs_valid", out_valid, 0);
        check("rs_data", data_out, 0);
        check("rs_done", pkt_done, 0);
        rst = 1'b0;
        exp_q.push_back(8'h00);
        exp_q.push_back(8'h02);
        for (int t = 0; t < 10 && grant == '0; t++) tick();
        check("rs_restart", grant, 4'b0001);
        for (int t = 0; t < 20 && exp_q.size() != 0; t++) tick();
        check("rs_drained", exp_q.size(), 0);
        tick();

        // maximum length packet on ch1
        rd_count[1] = 0;
        push_byte(1, 8'hF8, 1);
        for (int i = 0; i < 31; i++) push_byte(1, 8'h60 + 8'(i), 1);
        for (int t = 0; t < 60 && !pkt_done; t++) tick();
        check("max_done", pkt_done, 1);
        check("max_reads", rd_count[1], 32);
        check("max_idle", busy, 0);
        tick();
        check("max_reads_after", rd_count[1], 32);
        check("max_drained", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
